// File: rtl/i2s_tx_unit.sv
// rtl/i2s_tx_unit.sv - I2S transmitter: 4-deep stereo FIFO, 64-bit frames, sticky underrun/overrun flags
module i2s_tx_unit #(
    parameter int SCK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_in,
    input  logic        tick_in,
    input  logic [23:0] audio0_in,
    input  logic [23:0] audio1_in,
    input  logic        clr_in,
    output logic        req_out,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out,
    output logic        underrun_out,
    output logic        overrun_out
);
    localparam int CW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
    localparam logic [CW-1:0] CDIV_LAST = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] CDIV_HALF = CW'(SCK_DIV / 2);

    typedef enum logic {ST_STOP, ST_PLAY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cdiv_q, cdiv_d;
    logic [5:0]    idx_q, idx_d;
    logic [47:0]   frame_q, frame_d;
    logic [63:0]   frame_bits;
    logic          req_q, sck_q, ws_q, sdo_q, under_q, over_q;
    logic          sck_d, ws_d, sdo_d;
    logic          load, flush;

    logic [47:0]   fifo_mem_q [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q;
    logic          fifo_empty, fifo_full, pop, push, under_set, over_set;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    // An empty FIFO yields a zero frame; a same-cycle write is stored, never bypassed.
    assign pop        = load && !fifo_empty;
    assign push       = tick_in && (state_q == ST_PLAY) && !flush && (!fifo_full || pop);
    assign under_set  = load && fifo_empty;
    assign over_set   = tick_in && (state_q == ST_PLAY) && !flush && fifo_full && !pop;

    always_comb begin
        state_d    = state_q;
        cdiv_d     = cdiv_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        load       = 1'b0;
        flush      = 1'b0;
        frame_bits = '0;
        sck_d      = 1'b0;
        ws_d       = 1'b0;
        sdo_d      = 1'b0;

        case (state_q)
            ST_STOP: begin
                if (play_in) begin
                    state_d = ST_PLAY;
                    load    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (cdiv_q == CDIV_LAST) begin
                    cdiv_d = '0;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        if (play_in) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                            flush   = 1'b1;
                        end
                    end
                end else begin
                    cdiv_d = cdiv_q + CW'(1);
                end
            end
            default: state_d = ST_STOP;
        endcase

        if (load) begin
            frame_d = fifo_empty ? 48'd0 : fifo_mem_q[rd_ptr_q];
        end

        // Outputs are computed from next state so every pin comes straight from a flop.
        frame_bits = {frame_d[47:24], 8'h00, frame_d[23:0], 8'h00};
        if (state_d == ST_PLAY) begin
            sck_d = (cdiv_d >= CDIV_HALF);
            ws_d  = (idx_d >= 6'd31) && (idx_d <= 6'd62);
            sdo_d = frame_bits[6'd63 - idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STOP;
            cdiv_q   <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            req_q    <= 1'b0;
            sck_q    <= 1'b0;
            ws_q     <= 1'b0;
            sdo_q    <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cdiv_q  <= cdiv_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            req_q   <= load;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            sdo_q   <= sdo_d;
            under_q <= (under_q && !clr_in) || under_set;
            over_q  <= (over_q && !clr_in) || over_set;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
                count_q <= count_q + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {audio0_in, audio1_in};
    end

    assign req_out      = req_q;
    assign sck_out      = sck_q;
    assign ws_out       = ws_q;
    assign sdo_out      = sdo_q;
    assign underrun_out = under_q;
    assign overrun_out  = over_q;
endmodule
